// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants for the scan driver and the downstream seven-segment decoder
package led_pkg;
    localparam logic [3:0] CHAR_BLANK = 4'hF;
    localparam logic [3:0] CHAR_DASH  = 4'hD;
    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int         MSG_W      = 4 * NUM_DIGITS;
    localparam logic [MSG_W-1:0] RESET_MSG = 16'hFFFF;

    typedef logic [3:0] char_t;

    // Active-low one-hot anode pattern; digit 0 is the rightmost position.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [DIGIT_W-1:0] d);
        return ~(NUM_DIGITS'(1) << d);
    endfunction
endpackage

// File: rtl/led_scan_driver_if.sv
// rtl/led_scan_driver_if.sv - message load handshake between a producer and the scan driver
interface led_scan_driver_if;
    import led_pkg::*;

    logic [MSG_W-1:0] msg_in;
    logic             ld_valid;
    logic             ld_ready;

    modport master (output msg_in, output ld_valid, input ld_ready);
    modport slave  (input msg_in, input ld_valid, output ld_ready);
endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - per-slot cycle counter and digit index
module scan_tick_gen
    import led_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               slot_end_o,
    output logic [DIGIT_W-1:0] digit_o
);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;

    assign slot_end_o = (cnt_q == CNT_W'(DIV - 1));
    assign cnt_o      = cnt_q;
    assign digit_o    = digit_q;

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        if (slot_end_o) begin
            cnt_d   = '0;
            digit_d = digit_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end
endmodule

// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - four-digit multiplexed display scan driver with frame-aligned message loads
module led_scan_driver
    import led_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic               clk,
    input  logic               reset,
    led_scan_driver_if.slave   ld,
    input  logic               lz_blank_i,
    output logic [3:0]         an_o,
    output logic [3:0]         char_o,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               frame_done_o
);
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]   cnt;
    logic               slot_end;
    logic [DIGIT_W-1:0] digit;

    scan_tick_gen #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .cnt_o      (cnt),
        .slot_end_o (slot_end),
        .digit_o    (digit)
    );

    logic [MSG_W-1:0]   msg_q, msg_d, buf_q, buf_d;
    logic               pending_q, pending_d;
    logic [3:0]         an_q, an_d;
    char_t              char_q, char_d;
    logic [DIGIT_W-1:0] digit_q;
    logic               frame_done_q, frame_end;
    logic               dark, lz_hit;
    char_t              nib;

    assign frame_end   = slot_end && (digit == DIGIT_W'(NUM_DIGITS - 1));
    assign ld.ld_ready = ~pending_q;

    generate
        if (BLANK == 0) begin : g_no_dark
            assign dark = 1'b0;
        end else begin : g_dark
            assign dark = (cnt < CNT_W'(BLANK));
        end
    endgenerate

    // The swap reads buf_q before any same-cycle capture, so a load arriving
    // on the boundary waits for the following frame.
    always_comb begin
        msg_d     = msg_q;
        buf_d     = buf_q;
        pending_d = pending_q;
        if (frame_end && pending_q) begin
            msg_d     = buf_q;
            pending_d = 1'b0;
        end
        if (ld.ld_valid && !pending_q) begin
            buf_d     = ld.msg_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        nib    = msg_q[{digit, 2'b00} +: 4];
        lz_hit = 1'b0;
        case (digit)
            2'd3:    lz_hit = (msg_q[15:12] == 4'h0);
            2'd2:    lz_hit = (msg_q[15:8] == 8'h00);
            2'd1:    lz_hit = (msg_q[15:4] == 12'h000);
            default: lz_hit = 1'b0;
        endcase
        an_d   = dark ? 4'hF : anode_for(digit);
        char_d = (dark || (lz_blank_i && lz_hit)) ? CHAR_BLANK : nib;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q        <= RESET_MSG;
            buf_q        <= '0;
            pending_q    <= 1'b0;
            an_q         <= 4'hF;
            char_q       <= CHAR_BLANK;
            digit_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            msg_q        <= msg_d;
            buf_q        <= buf_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            char_q       <= char_d;
            digit_q      <= digit;
            frame_done_q <= frame_end;
        end
    end

    assign an_o         = an_q;
    assign char_o       = char_q;
    assign digit_o      = digit_q;
    assign frame_done_o = frame_done_q;
endmodule
